// File: rtl/fp_norm_pack.sv
// fp_norm_pack
//   Post-adder normalizer and IEEE-754 binary32 packer. Takes the 25-bit
//   aligned magnitude sum (bit24 = carry, bit23 = hidden bit), the result
//   sign and the larger biased exponent. It normalizes the sum with one left
//   shift per cycle, rounds or truncates the carry case, and returns a packed
//   result over a valid/ready handshake.
//
//   Optional feature macro: FP_NORM_PACK_ROUND_EN
//     defined   -> round-to-nearest-even on the bit dropped by the carry shift
//     undefined -> truncate the dropped bit
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   input word valid
//   in_ready   out  1   high while idle (can accept)
//   sum_in     in  25   aligned magnitude sum
//   sign_in    in   1   result sign
//   exp_in     in   8   biased exponent of the larger operand
//   out_valid  out  1   result valid
//   out_ready  in   1   downstream accepts result
//   result     out 32   packed {sign, exp[7:0], frac[22:0]}
//   overflow   out  1   result saturated to infinity (qualified by out_valid)

module fp_norm_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] sum_in,
   input  logic        sign_in,
   input  logic [7:0]  exp_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [24:0] sum_q,   sum_d;
   logic        sign_q,  sign_d;
   logic [8:0]  e_q,     e_d;
   logic        pass_q,  pass_d;
   logic [31:0] result_q, result_d;
   logic        ovf_q,   ovf_d;

   // Carry-path working values
   logic        round_up_s;
   logic [24:0] mant_r_s;
   logic [8:0]  e_carry_s;
   logic [22:0] frac_carry_s;

   // Pack sign/exponent/fraction, saturating to infinity when the exponent
   // has run past the largest finite encoding. Returns {overflow, word}.
   function automatic logic [32:0] pack_word(input logic        sign,
                                             input logic [8:0]  e,
                                             input logic [22:0] frac);
      logic [32:0] w;
      if (e >= 9'd255) begin
         w = {1'b1, sign, 8'hFF, 23'd0};
      end else begin
         w = {1'b0, sign, e[7:0], frac};
      end
      return w;
   endfunction

   // Carry-path mantissa: right shift by one, optional RNE, carry-out renorm
   always_comb begin
`ifdef FP_NORM_PACK_ROUND_EN
      // A single guard bit means any dropped 1 is a tie: round to even.
      round_up_s = sum_q[0] & sum_q[1];
`else
      round_up_s = 1'b0;
`endif
      mant_r_s = {1'b0, sum_q[24:1]} + {24'd0, round_up_s};
      if (mant_r_s[24]) begin
         // Mantissa rounded up to 2.0: becomes 1.0 with one more exponent step
         frac_carry_s = 23'd0;
         e_carry_s    = e_q + 9'd2;
      end else begin
         frac_carry_s = mant_r_s[22:0];
         e_carry_s    = e_q + 9'd1;
      end
   end

   // Next-state and datapath decisions
   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      sign_d   = sign_q;
      e_d      = e_q;
      pass_d   = pass_q;
      result_d = result_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sum_d   = sum_in;
               sign_d  = sign_in;
               // Exponent 0 (denormal) scales like exponent 1
               e_d     = (exp_in == 8'd0) ? 9'd1 : {1'b0, exp_in};
               pass_d  = (exp_in == 8'hFF);
               state_d = NORM;
            end else begin
               state_d = IDLE;
            end
         end
         NORM: begin
            if (pass_q) begin
               result_d = {sign_q, 8'hFF, sum_q[22:0]};
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else if (sum_q == 25'd0) begin
               result_d = {sign_q, 31'd0};
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else if (sum_q[24]) begin
               {ovf_d, result_d} = pack_word(sign_q, e_carry_s, frac_carry_s);
               state_d           = DONE;
            end else if (sum_q[23]) begin
               {ovf_d, result_d} = pack_word(sign_q, e_q, sum_q[22:0]);
               state_d           = DONE;
            end else if (e_q == 9'd1) begin
               // Cannot shift further without going below the minimum exponent
               result_d = {sign_q, 8'h00, sum_q[22:0]};
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else begin
               sum_d   = {sum_q[23:0], 1'b0};
               e_d     = e_q - 9'd1;
               state_d = NORM;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sum_q    <= 25'd0;
         sign_q   <= 1'b0;
         e_q      <= 9'd0;
         pass_q   <= 1'b0;
         result_q <= 32'd0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         sign_q   <= sign_d;
         e_q      <= e_d;
         pass_q   <= pass_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fp_norm_pack.sv
module tb_fp_norm_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] sum_in;
   logic        sign_in;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;

   int total = 0;
   int bad   = 0;

`ifdef FP_NORM_PACK_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   fp_norm_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_in    (sum_in),
      .sign_in   (sign_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model: leading-one search instead of iterative shifting
   function automatic exp_t model(input logic [24:0] s, input logic sg, input logic [7:0] ex);
      exp_t r;
      int e;
      int p;
      int n;
      logic [24:0] m;
      logic [24:0] t;
      e = (ex == 8'd0) ? 1 : int'(ex);
      r.ovf = 1'b0;
      r.lat = 2;
      if (ex == 8'hFF) begin
         r.res = {sg, 8'hFF, s[22:0]};
      end else if (s == 25'd0) begin
         r.res = {sg, 31'd0};
      end else if (s[24]) begin
         m = {1'b0, s[24:1]};
         if (ROUND && s[1] && s[0]) m = m + 25'd1;
         e = e + 1;
         if (m == 25'h1000000) begin
            m = 25'h0800000;
            e = e + 1;
         end
         if (e >= 255) begin
            r.res = {sg, 8'hFF, 23'd0};
            r.ovf = 1'b1;
         end else begin
            r.res = {sg, 8'(e), m[22:0]};
         end
      end else begin
         p = -1;
         for (int i = 23; i >= 0; i--) begin
            if (p < 0 && s[i]) p = i;
         end
         n = 23 - p;
         if (n > e - 1) n = e - 1;
         t = s << n;
         e = e - n;
         r.lat = 2 + n;
         if (t[23]) r.res = {sg, 8'(e), t[22:0]};
         else       r.res = {sg, 8'h00, t[22:0]};
      end
      return r;
   endfunction

   // Drive one operand, then check result, overflow, latency and handshake
   task automatic run_op(input string tag, input logic [24:0] s, input logic sg,
                         input logic [7:0] ex, input int hold, input exp_t e);
      exp_t got;
      int c;
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
      sum_in    = s;
      sign_in   = sg;
      exp_in    = ex;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      sum_in   = 25'h1555555;
      exp_in   = 8'h5A;
      c = 0;
      while (!out_valid && c < 40) begin
         @(posedge clk);
         c++;
         @(negedge clk);
      end
      if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      got = sb_q.pop_front();
      for (int h = 0; h < hold; h++) begin
         check({tag, "_hold_res"}, result, got.res);
         check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
         check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      check({tag, "_res"}, result, got.res);
      check({tag, "_ovf"}, 32'(overflow), 32'(got.ovf));
      check({tag, "_lat"}, 32'(c + 1), 32'(got.lat));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
      check({tag, "_vld_low"}, 32'(out_valid), 32'd0);
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic o, input int l);
      exp_t x;
      x.res = r;
      x.ovf = o;
      x.lat = l;
      return x;
   endfunction

   initial begin
      logic [24:0] rs;
      logic [7:0]  re;
      logic        rg;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      sum_in    = 25'd0;
      sign_in   = 1'b0;
      exp_in    = 8'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_res", result, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_inrdy", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      run_op("norm",   25'h0800000, 1'b0, 8'd127, 0, mk(32'h3F800000, 1'b0, 2));
      run_op("carry",  25'h1800000, 1'b0, 8'd127, 0, mk(32'h40400000, 1'b0, 2));
      run_op("round",  25'h1FFFFFF, 1'b0, 8'd127, 0,
             mk(ROUND ? 32'h40800000 : 32'h407FFFFF, 1'b0, 2));
      run_op("long",   25'h0000001, 1'b0, 8'd127, 0, mk(32'h34000000, 1'b0, 25));
      run_op("denorm", 25'h0000100, 1'b0, 8'd3,   0, mk(32'h00000400, 1'b0, 4));
      run_op("ovf",    25'h1000000, 1'b0, 8'd254, 0, mk(32'h7F800000, 1'b1, 2));
      run_op("zero",   25'h0000000, 1'b1, 8'd100, 3, mk(32'h80000000, 1'b0, 2));
      run_op("pass",   25'h0400000, 1'b1, 8'd255, 0, mk(32'hFFC00000, 1'b0, 2));
      run_op("exp0",   25'h0800000, 1'b0, 8'd0,   1, mk(32'h00800000, 1'b0, 2));
      run_op("dn_e0",  25'h0000010, 1'b1, 8'd0,   0, mk(32'h80000010, 1'b0, 2));

      // Reset in the middle of a long shift sequence
      @(negedge clk);
      sum_in   = 25'h0000001;
      sign_in  = 1'b0;
      exp_in   = 8'd127;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_vld", 32'(out_valid), 32'd0);
      check("mid_rst_inrdy", 32'(in_ready), 32'd1);
      check("mid_rst_res", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("post_rst", 25'h0C00000, 1'b0, 8'd130, 0, mk(32'h41400000, 1'b0, 2));

      // Randomized operands checked against the model
      for (int k = 0; k < 30; k++) begin
         rs = 25'($urandom) >> $urandom_range(0, 24);
         re = 8'($urandom_range(0, 255));
         rg = 1'($urandom);
         run_op("rand", rs, rg, re, $urandom_range(0, 2), model(rs, rg, re));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_norm_pack.md
# fp_norm_pack

Post-adder normalizer and IEEE-754 single-precision packer for the floating-point add/sub datapath. It accepts the raw 25-bit aligned sum from `control` (`out`/`sign_out`) together with the larger biased exponent, and normalizes the mantissa. Left shifts are done iteratively, one bit per cycle. It then rounds and emits a packed 32-bit result over a valid/ready handshake.

## Interface
Parameters: none (fixed to binary32).

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  block idle, can accept; `in_ready = (state == IDLE)`
- `sum_in`  in  25  aligned magnitude sum; bit24 carry, bit23 hidden-bit position
- `sign_in`  in  1  result sign
- `exp_in`  in  8  biased exponent of the larger operand
- `out_valid`  out  1  `result` valid
- `out_ready`  in  1  downstream accepts result
- `result`  out  32  packed `{sign, exp[7:0], frac[22:0]}`
- `overflow`  out  1  result saturated to infinity; qualified by `out_valid`

## Operation
- The FSM has three states: IDLE, NORM and DONE.
- IDLE:
  - When `in_valid && in_ready`, register `sum_in`, `sign_in` and `exp_in`, then go to NORM.
  - Effective exponent `e` is a 9-bit value equal to `exp_in`, except that `exp_in == 0` is treated as `e = 1`.
- NORM (evaluated in priority order, one decision per cycle):
  1. `exp_in == 255`: pass through as `{sign, 8'hFF, sum[22:0]}`, then DONE.
  2. `sum == 0`: result is `{sign, 31'b0}`, then DONE.
  3. `sum[24]`: shift right 1, `e = e + 1`, apply rounding (see Configuration), pack, then DONE.
  4. `sum[23]`: pack `{sign, e[7:0], sum[22:0]}`, then DONE.
  5. `e == 1` with `sum[23] == 0`: denormal; pack `{sign, 8'h00, sum[22:0]}`, then DONE.
  6. Otherwise: `sum <<= 1`, `e = e - 1`, stay in NORM.
- Rounding carry-out:
  - If the rounded mantissa reaches `25'h1000000`, set mantissa to `24'h800000` and `e = e + 1`.
- Overflow:
  - If the final `e >= 255` on a non-passthrough path, result is `{sign, 8'hFF, 23'b0}` and `overflow = 1`.
- DONE:
  - `out_valid = 1`. `result` and `overflow` are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
  - There is no bypass: a new input is accepted at the earliest one cycle after the handshake.
- Reset:
  - `rst_n == 0` at a clock edge forces IDLE and clears `result`, `overflow` and `out_valid` to 0.
  - Reset applies from any state, including mid-shift. The in-flight operand is discarded.
- Reset values: `out_valid = 0`, `result = 32'h0`, `overflow = 0`, `in_ready = 1`.

## Timing
- Input is accepted at edge k. NORM is active in cycle k+1.
- For a zero or already-normalized sum, `out_valid` rises after edge k+1, i.e. 2 cycles after acceptance.
- Each left shift adds 1 cycle. Worst case is `sum_in = 1` with a large `e`: 23 shifts, giving 25 cycles.
- Denormal exit bounds the shift count at `e - 1`.
- `in_ready` is low from the cycle after acceptance until the cycle after the output handshake.
- `out_ready` may be high before `out_valid`; the handshake then completes in the first DONE cycle.
- `in_valid` is ignored while not in IDLE. Upstream must hold its data until `in_ready`.

## Configuration
- Macro: `FP_NORM_PACK_ROUND_EN`.
- Defined: round-to-nearest-even on the bit dropped by the right shift in step 3.
  - Only a single guard bit is available, so a dropped 1 is always a tie.
  - Round up iff the dropped bit and the kept LSB are both 1.
  - Carry-out and overflow handling apply as in Operation.
- Undefined: truncate; the dropped bit is discarded. Rounding carry-out cannot occur.
- All other behaviour is identical with or without the macro.

## Test plan
- Normalized input: `sum_in = 25'h0800000`, `exp_in = 127`, `sign_in = 0`, `out_ready = 1` -> `result = 32'h3F800000` with `out_valid` 2 cycles after accept, `overflow = 0`.
- Carry input: `sum_in = 25'h1800000`, `exp_in = 127` -> `32'h40400000`.
- Round on carry: `sum_in = 25'h1FFFFFF`, `exp_in = 127` -> `32'h40800000` with the macro defined, `32'h407FFFFF` without it.
- Long shift: `sum_in = 25'h0000001`, `exp_in = 127` -> `32'h34000000`, `out_valid` 25 cycles after accept.
- Denormal: `sum_in = 25'h0000100`, `exp_in = 3` -> 2 shifts -> `32'h00000400`.
- Overflow: `sum_in = 25'h1000000`, `exp_in = 254` -> `32'h7F800000`, `overflow = 1`.
- Zero with backpressure and reset:
  - `sum_in = 0`, `sign_in = 1`, `exp_in = 100`, `out_ready = 0` for 3 cycles -> `32'h80000000` held stable, `in_ready = 0`; then `out_ready = 1` -> IDLE.
  - Separately, assert `rst_n = 0` mid-shift -> next cycle `out_valid = 0`, `in_ready = 1`.
